array_match: RTL and testbench

- Parallel equality matcher: compares each of SIZE packed WIDTH-bit elements of `in` against `match_value`.
- Produces a per-element hit mask plus summary outputs: any-hit, hit count, lowest hit index.
- Used as a lookup/CAM-style primitive in datapaths that need a one-hot or multi-hot select from a small array.
- Outputs are registered: one clock of latency.

---
 rtl/array_match_pkg.sv | 23 ++
 rtl/array_match_cmp.sv | 38 +++
 rtl/array_match.sv | 71 +++++++
 tb/tb_array_match.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/array_match_pkg.sv
// Shared types and width helpers for the array_match equality matcher.
package array_match_pkg;

    // Comparator structure choices; all produce identical masks.
    typedef enum logic [1:0] {
        IMPL_LOOP   = 2'd0,
        IMPL_GEN    = 2'd1,
        IMPL_MATRIX = 2'd2
    } impl_e;

    // Index width that never collapses to zero bits (SIZE = 1 still needs a port bit).
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Width able to hold a population count from 0 up to and including n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/array_match_cmp.sv
// Combinational per-element equality compare; produces only the hit mask.
module array_match_cmp
    import array_match_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SIZE  = 8,
    parameter int IMPL  = 1
) (
    input  logic [SIZE-1:0][WIDTH-1:0] in,
    input  logic [WIDTH-1:0]           match_value,
    output logic [SIZE-1:0]            mask_c
);

    if (IMPL == int'(IMPL_LOOP)) begin : g_loop
        // Plain procedural full-width equality per element.
        always_comb begin
            mask_c = '0;
            for (int j = 0; j < SIZE; j++) begin
                mask_c[j] = (in[j] == match_value);
            end
        end
    end else if (IMPL == int'(IMPL_GEN)) begin : g_gen
        // One XNOR row per element, AND-reduced to a single hit bit.
        for (genvar j = 0; j < SIZE; j++) begin : g_elem
            assign mask_c[j] = &(in[j] ~^ match_value);
        end
    end else if (IMPL == int'(IMPL_MATRIX)) begin : g_matrix
        // Full mismatch matrix first, then OR-reduce each row; no mismatch means hit.
        logic [SIZE-1:0][WIDTH-1:0] diff;
        for (genvar j = 0; j < SIZE; j++) begin : g_row
            assign diff[j]   = in[j] ^ match_value;
            assign mask_c[j] = ~|diff[j];
        end
    end else begin : g_bad
        $fatal(1, "array_match_cmp: IMPL must be 0, 1 or 2");
    end

endmodule

// File: rtl/array_match.sv
// Parallel equality matcher: registered hit mask, any-hit, hit count and
// lowest hit index, one clock of latency.
// There is no valid/ready handshake and no enable: in and match_value are
// sampled on every rising clk and the result appears right after that edge.
module array_match
    import array_match_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SIZE  = 8,
    parameter int IMPL  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SIZE-1:0][WIDTH-1:0]      in,
    input  logic [WIDTH-1:0]                match_value,
    output logic [SIZE-1:0]                 output_mask,
    output logic                            match_any,
    output logic [$clog2(SIZE+1)-1:0]       match_count,
    output logic [clog2_min1(SIZE)-1:0]     first_idx
);

    localparam int CW = count_width(SIZE);
    localparam int IW = clog2_min1(SIZE);

    logic [SIZE-1:0] mask_c;
    logic            any_c;
    logic [CW-1:0]   count_c;
    logic [IW-1:0]   first_c;

    array_match_cmp #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .IMPL  (IMPL)
    ) u_cmp (
        .in          (in),
        .match_value (match_value),
        .mask_c      (mask_c)
    );

    // Summary of the mask: any-hit, population count, lowest set index.
    always_comb begin
        any_c   = |mask_c;
        count_c = '0;
        first_c = '0;
        for (int j = 0; j < SIZE; j++) begin
            count_c = count_c + CW'(mask_c[j]);
        end
        // Scan downward so the lowest hit is the last one written.
        for (int j = SIZE - 1; j >= 0; j--) begin
            if (mask_c[j]) begin
                first_c = IW'(j);
            end
        end
    end

    // Output register; reset clears immediately and drops any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_mask <= '0;
            match_any   <= 1'b0;
            match_count <= '0;
            first_idx   <= '0;
        end else begin
            output_mask <= mask_c;
            match_any   <= any_c;
            match_count <= count_c;
            first_idx   <= first_c;
        end
    end

endmodule

// File: tb/tb_array_match.sv
// Bench for array_match: three instances (IMPL 0/1/2) driven in parallel and
// each checked against hand-computed vectors and a one-cycle-delayed model.
module tb_array_match;

    localparam int WIDTH = 4;
    localparam int SIZE  = 8;
    localparam int NIMPL = 3;
    localparam int RW    = SIZE + 1 + 4 + 3;

    logic                        clk;
    logic                        rst;
    logic [SIZE-1:0][WIDTH-1:0]  in_d;
    logic [WIDTH-1:0]            mv_d;

    logic [SIZE-1:0] mask_o  [NIMPL];
    logic            any_o   [NIMPL];
    logic [3:0]      count_o [NIMPL];
    logic [2:0]      first_o [NIMPL];

    int n_checks;
    int n_pass;

    logic [RW-1:0] exp_q[$];

    typedef struct {
        logic [31:0] in_v;
        logic [3:0]  mv;
        logic [7:0]  e_mask;
        logic        e_any;
        logic [3:0]  e_count;
        logic [2:0]  e_first;
        string       name;
    } vec_t;

    vec_t vecs[7];

    for (genvar g = 0; g < NIMPL; g++) begin : g_dut
        array_match #(
            .WIDTH (WIDTH),
            .SIZE  (SIZE),
            .IMPL  (g)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in          (in_d),
            .match_value (mv_d),
            .output_mask (mask_o[g]),
            .match_any   (any_o[g]),
            .match_count (count_o[g]),
            .first_idx   (first_o[g])
        );
    end

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: independent scan of the elements.
    function automatic logic [RW-1:0] model(input logic [31:0] v, input logic [3:0] m);
        logic [7:0] mk;
        logic [3:0] c;
        logic [2:0] f;
        logic       found;
        mk = '0; c = '0; f = '0; found = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
            if (v[j*4 +: 4] == m) begin
                mk[j] = 1'b1;
                c = c + 4'd1;
                if (!found) begin
                    f = 3'(j);
                    found = 1'b1;
                end
            end
        end
        return {mk, found, c, f};
    endfunction

    task automatic check_all(input string name, input logic [RW-1:0] exp_r);
        logic [RW-1:0] got;
        for (int k = 0; k < NIMPL; k++) begin
            got = {mask_o[k], any_o[k], count_o[k], first_o[k]};
            n_checks++;
            if (got === exp_r) begin
                n_pass++;
            end else begin
                $display("FAIL %s impl=%0d got mask=%b any=%b count=%0d first=%0d want mask=%b any=%b count=%0d first=%0d",
                         name, k, got[15:8], got[7], got[6:3], got[2:0],
                         exp_r[15:8], exp_r[7], exp_r[6:3], exp_r[2:0]);
            end
        end
    endtask

    // Driver: present new inputs away from the active edge.
    task automatic drive(input logic [31:0] v, input logic [3:0] m);
        @(negedge clk);
        in_d = v;
        mv_d = m;
    endtask

    // Advance past the next active edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rv;
        logic [RW-1:0] e;
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{32'h21332123, 4'd2, 8'b10001010, 1'b1, 4'd3, 3'd1, "base_mv2"};
        vecs[1] = '{32'h11111111, 4'd2, 8'b00000000, 1'b0, 4'd0, 3'd0, "no_hit"};
        vecs[2] = '{32'h22222222, 4'd2, 8'b11111111, 1'b1, 4'd8, 3'd0, "all_hit"};
        vecs[3] = '{32'h21332123, 4'd3, 8'b00110001, 1'b1, 4'd3, 3'd0, "base_mv3"};
        vecs[4] = '{32'h21111111, 4'd2, 8'b10000000, 1'b1, 4'd1, 3'd7, "top_only"};
        vecs[5] = '{32'h00000008, 4'd0, 8'b11111110, 1'b1, 4'd7, 3'd1, "msb_differs"};
        vecs[6] = '{32'hA5A5A5A5, 4'd5, 8'b01010101, 1'b1, 4'd4, 3'd0, "even_hits"};

        // Reset with random inputs: outputs clear before any clock edge.
        rst  = 1'b1;
        in_d = $urandom;
        mv_d = 4'($urandom_range(0, 15));
        #2;
        check_all("reset_async", '0);
        step();
        step();
        check_all("reset_held", '0);

        // Release reset, first capture on the first edge after release.
        @(negedge clk);
        rst  = 1'b0;
        in_d = 32'h21332123;
        mv_d = 4'd2;
        #1;
        check_all("pre_first_edge", '0);
        step();
        check_all("first_capture", model(32'h21332123, 4'd2));

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].in_v, vecs[i].mv);
            step();
            check_all(vecs[i].name, {vecs[i].e_mask, vecs[i].e_any, vecs[i].e_count, vecs[i].e_first});
        end

        // Key change only: previous result still visible until the next edge.
        drive(32'h21332123, 4'd2);
        step();
        drive(32'h21332123, 4'd3);
        #1;
        check_all("key_change_old", {8'b10001010, 1'b1, 4'd3, 3'd1});
        step();
        check_all("key_change_new", {8'b00110001, 1'b1, 4'd3, 3'd0});

        // Reset mid-stream with a hit pending.
        drive(32'h22222222, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        check_all("mid_reset_async", '0);
        step();
        check_all("mid_reset_edge", '0);
        @(negedge clk);
        rst  = 1'b0;
        in_d = 32'h11111111;
        mv_d = 4'd2;
        step();
        check_all("mid_reset_release", '0);
        step();
        check_all("mid_reset_settled", '0);

        // Random regression against the model, all three structures.
        for (int i = 0; i < 16; i++) begin
            rv = '0;
            for (int j = 0; j < SIZE; j++) begin
                rv[j*4 +: 4] = 4'($urandom_range(1, 3));
            end
            drive(rv, 4'd2);
            exp_q.push_back(model(rv, 4'd2));
            step();
            e = exp_q.pop_front();
            check_all("random", e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
